mem_ctrl_seq: RTL and testbench

Multi-byte, arbitrating memory controller between the CPU pipeline and the byte-wide system RAM. It accepts whole-access requests from instruction fetch (IF, always 4 bytes) and from the MEM stage (load/store of 1, 2 or 4 bytes). It sequences each request as consecutive single-byte RAM cycles and assembles or disassembles little-endian data. It replaces the per-byte pass-through controller, so IF and MEM no longer count bytes themselves.

---
 rtl/mem_ctrl_seq.sv | 158 +++++++++++++++
 tb/tb_mem_ctrl_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_seq.sv
// Arbitrating multi-byte memory controller: sequences IF fetches and MEM loads/stores
// as consecutive single-byte RAM cycles with little-endian assembly and load extension.
module mem_ctrl_seq #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic [1:0]        mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              busy,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  // Cycle counter spans address issue plus read latency: up to 4 + RAM_LAT - 1.
  localparam int unsigned CW = $clog2(RAM_LAT + 5) + 1;

  state_t            state, state_nx;
  logic [CW-1:0]     cyc;
  logic [ADDR_W-1:0] base;
  logic [2:0]        nbytes;
  logic [1:0]        size_r;
  logic              uns_r;
  logic              own_mem;
  logic [31:0]       wdata_r;
  logic [31:0]       rbuf;
  logic [31:0]       rbuf_nx;
  logic [31:0]       ext;

  logic              mem_sel;
  logic              accept;
  logic [1:0]        req_size;
  logic [2:0]        req_n;
  logic              cap_en;
  logic [CW-1:0]     cap_cnt;
  logic              rd_last;
  logic              wr_last;

  always_comb begin
    mem_sel  = (mem_req == 2'b01) || (mem_req == 2'b10);
    accept   = mem_sel || if_req;
    req_size = mem_sel ? mem_size : 2'b10;
    case (req_size)
      2'b00:   req_n = 3'd1;
      2'b01:   req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
  end

  // Byte i returns RAM_LAT cycles after its address, so capture trails issue.
  always_comb begin
    cap_en  = (state == READ) && (cyc >= CW'(RAM_LAT));
    cap_cnt = cyc - CW'(RAM_LAT);
    rbuf_nx = rbuf;
    if (cap_en) begin
      rbuf_nx[{cap_cnt[1:0], 3'b000} +: 8] = ram_din;
    end
    case (size_r)
      2'b00:   ext = {{24{~uns_r & rbuf_nx[7]}}, rbuf_nx[7:0]};
      2'b01:   ext = {{16{~uns_r & rbuf_nx[15]}}, rbuf_nx[15:0]};
      default: ext = rbuf_nx;
    endcase
  end

  always_comb begin
    rd_last  = (cyc == CW'(nbytes) + CW'(RAM_LAT - 1));
    wr_last  = (cyc == CW'(nbytes) - CW'(1));
    state_nx = state;
    case (state)
      IDLE: begin
        if (mem_req == 2'b01)      state_nx = READ;
        else if (mem_req == 2'b10) state_nx = WRITE;
        else if (if_req)           state_nx = READ;
      end
      READ:    if (rd_last) state_nx = DONE;
      WRITE:   if (wr_last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= '0;
      base      <= '0;
      nbytes    <= 3'd0;
      size_r    <= 2'b00;
      uns_r     <= 1'b0;
      own_mem   <= 1'b0;
      wdata_r   <= '0;
      rbuf      <= '0;
      if_data   <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          cyc  <= '0;
          rbuf <= '0;
          if (accept) begin
            base    <= mem_sel ? mem_addr : if_addr;
            size_r  <= req_size;
            nbytes  <= req_n;
            uns_r   <= mem_unsigned & mem_sel;
            own_mem <= mem_sel;
            wdata_r <= mem_wdata;
          end
        end
        READ: begin
          cyc  <= cyc + CW'(1);
          rbuf <= rbuf_nx;
          // Result registers load on the final capture so they are valid in DONE.
          if (rd_last) begin
            if (own_mem) mem_rdata <= ext;
            else         if_data   <= ext;
          end
        end
        WRITE:   cyc <= cyc + CW'(1);
        default: cyc <= '0;
      endcase
    end
  end

  always_comb begin
    ram_a    = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    busy     = (state != IDLE);
    if_done  = (state == DONE) && !own_mem;
    mem_done = (state == DONE) && own_mem;
    case (state)
      READ: begin
        if (cyc < CW'(nbytes)) ram_a = base + ADDR_W'(cyc);
      end
      WRITE: begin
        ram_a    = base + ADDR_W'(cyc);
        ram_dout = wdata_r[{cyc[1:0], 3'b000} +: 8];
        ram_wr   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl_seq.sv
// Self-checking bench for mem_ctrl_seq: directed scenarios plus randomized accesses
// checked against a byte-array reference model of RAM contents.
module tb_mem_ctrl_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_if_req, a_if_done, a_mem_unsigned, a_mem_done, a_busy, a_ram_wr;
  logic [31:0] a_if_addr, a_if_data, a_mem_addr, a_mem_wdata, a_mem_rdata, a_ram_a;
  logic [1:0]  a_mem_req, a_mem_size;
  logic [7:0]  a_ram_din, a_ram_dout;

  logic        b_if_req, b_if_done, b_mem_unsigned, b_mem_done, b_busy, b_ram_wr;
  logic [15:0] b_if_addr, b_mem_addr, b_ram_a;
  logic [31:0] b_if_data, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_mem_req, b_mem_size;
  logic [7:0]  b_ram_din, b_ram_dout, b_d1;

  mem_ctrl_seq #(.ADDR_W(32), .RAM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .if_req(a_if_req), .if_addr(a_if_addr), .if_done(a_if_done),
    .if_data(a_if_data), .mem_req(a_mem_req), .mem_addr(a_mem_addr), .mem_size(a_mem_size),
    .mem_unsigned(a_mem_unsigned), .mem_wdata(a_mem_wdata), .mem_done(a_mem_done),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .ram_din(a_ram_din), .ram_dout(a_ram_dout),
    .ram_a(a_ram_a), .ram_wr(a_ram_wr));

  mem_ctrl_seq #(.ADDR_W(16), .RAM_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .if_req(b_if_req), .if_addr(b_if_addr), .if_done(b_if_done),
    .if_data(b_if_data), .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_size(b_mem_size),
    .mem_unsigned(b_mem_unsigned), .mem_wdata(b_mem_wdata), .mem_done(b_mem_done),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .ram_din(b_ram_din), .ram_dout(b_ram_dout),
    .ram_a(b_ram_a), .ram_wr(b_ram_wr));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t wlog[$];

  // RAM models: A has 1-cycle read latency, B has 2; background content set on first edge.
  logic [7:0]  mema [4096];
  logic [7:0]  memb [65536];
  bit          a_init = 1'b0, b_init = 1'b0;
  logic        pa_we = 1'b0, pb_we = 1'b0;
  logic [11:0] pa_addr;
  logic [15:0] pb_addr;
  logic [7:0]  pa_d, pb_d;

  always @(posedge clk) begin
    if (!a_init) begin
      for (int i = 0; i < 4096; i++) mema[i] <= 8'(i * 37 + 11);
      a_init <= 1'b1;
    end else begin
      if (pa_we) mema[pa_addr] <= pa_d;
      if (a_ram_wr) begin
        mema[a_ram_a[11:0]] <= a_ram_dout;
        wlog.push_back('{cyc, a_ram_a, a_ram_dout});
      end
    end
    a_ram_din <= mema[a_ram_a[11:0]];
  end

  always @(posedge clk) begin
    if (!b_init) begin
      for (int i = 0; i < 65536; i++) memb[i] <= 8'h00;
      b_init <= 1'b1;
    end else if (pb_we) memb[pb_addr] <= pb_d;
    else if (b_ram_wr) memb[b_ram_a] <= b_ram_dout;
    b_d1      <= memb[b_ram_a];
    b_ram_din <= b_d1;
  end

  // Reference model: expected RAM A contents and load semantics as plain arithmetic.
  logic [7:0] refa [4096];

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n, input bit uns);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(refa[12'(addr + 32'(i))]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] addr, input int n, input logic [31:0] wd);
    logic [31:0] w = wd;
    for (int i = 0; i < n; i++) refa[12'(addr + 32'(i))] = w[8*i +: 8];
  endtask

  task automatic poke_a(input logic [11:0] addr, input logic [7:0] d);
    pa_addr = addr; pa_d = d; pa_we = 1'b1;
    @(posedge clk); #1;
    pa_we = 1'b0;
    refa[addr] = d;
  endtask

  task automatic poke_b(input logic [15:0] addr, input logic [7:0] d);
    pb_addr = addr; pb_d = d; pb_we = 1'b1;
    @(posedge clk); #1;
    pb_we = 1'b0;
  endtask

  // Drivers: request driven in an IDLE cycle T; lat = cycles from T to done (-1 on timeout).
  // They return one cycle after done, with 'again' = the done level in that cycle.
  task automatic run_mem(input logic [1:0] op, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat, output int t0, output logic again);
    a_mem_req = op; a_mem_addr = addr; a_mem_size = sz; a_mem_unsigned = uns; a_mem_wdata = wd;
    t0 = cyc; lat = -1; rd = '0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (a_mem_done) begin lat = k; rd = a_mem_rdata; end
    end
    a_mem_req = 2'b00;
    @(posedge clk); #1;
    again = a_mem_done;
  endtask

  task automatic run_fetch(input logic [31:0] addr, output logic [31:0] rd, output int lat,
                           output logic again);
    a_if_req = 1'b1; a_if_addr = addr; lat = -1; rd = '0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (a_if_done) begin lat = k; rd = a_if_data; end
    end
    a_if_req = 1'b0;
    @(posedge clk); #1;
    again = a_if_done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({a_if_done, a_mem_done, a_busy, a_ram_wr} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b want=0000", {a_if_done, a_mem_done, a_busy, a_ram_wr});
    end
    n_tests++;
    if ({a_if_data, a_mem_rdata, a_ram_a, a_ram_dout} !== '0) begin
      n_fail++; $display("FAIL reset_data if_data=%h mem_rdata=%h ram_a=%h ram_dout=%h want 0",
                         a_if_data, a_mem_rdata, a_ram_a, a_ram_dout);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy got=%b/%b want=0/0", a_busy, b_busy);
    end
  endtask

  task automatic test_fetch;
    logic [31:0] rd; int lat; logic again; int w0;
    poke_a(12'h100, 8'h13); poke_a(12'h101, 8'h05); poke_a(12'h102, 8'hA0); poke_a(12'h103, 8'h00);
    w0 = wlog.size();
    run_fetch(32'h100, rd, lat, again);
    n_tests++;
    if (lat !== 6) begin n_fail++; $display("FAIL fetch_latency got=%0d want=6", lat); end
    n_tests++;
    if (rd !== 32'h00A00513) begin n_fail++; $display("FAIL fetch_data got=%h want=00a00513", rd); end
    n_tests++;
    if (again !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse got=%b want=0", again); end
    n_tests++;
    if (wlog.size() !== w0) begin n_fail++; $display("FAIL fetch_no_write got=%0d want=%0d", wlog.size(), w0); end
  endtask

  task automatic test_load_ext;
    logic [1:0]  sz_t [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        un_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ex_t [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFF80, 32'h0000FF80};
    int          lt_t [4] = '{3, 3, 4, 4};
    logic [31:0] rd; int lat, t0; logic again;
    poke_a(12'h020, 8'h80); poke_a(12'h021, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      run_mem(2'b01, 32'h20, sz_t[i], un_t[i], '0, rd, lat, t0, again);
      n_tests++;
      if (rd !== ex_t[i] || lat !== lt_t[i]) begin
        n_fail++; $display("FAIL load_ext[%0d] got=%h/lat%0d want=%h/lat%0d", i, rd, lat, ex_t[i], lt_t[i]);
      end
    end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; int lat, t0; logic again; int w0;
    logic [7:0] exp_b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    w0 = wlog.size();
    run_mem(2'b10, 32'h41, 2'b10, 1'b0, 32'h12345678, rd, lat, t0, again);
    ref_store(32'h41, 4, 32'h12345678);
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL store_latency got=%0d want=5", lat); end
    n_tests++;
    if (wlog.size() !== w0 + 4) begin
      n_fail++; $display("FAIL store_count got=%0d want=%0d", wlog.size() - w0, 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (wlog[w0+i].c !== t0 + 1 + i || wlog[w0+i].a !== 32'h41 + 32'(i) || wlog[w0+i].d !== exp_b[i]) begin
          n_fail++; $display("FAIL store_byte[%0d] got=c%0d a%h d%h want=c%0d a%h d%h", i, wlog[w0+i].c,
                             wlog[w0+i].a, wlog[w0+i].d, t0 + 1 + i, 32'h41 + 32'(i), exp_b[i]);
        end
      end
    end
    run_mem(2'b01, 32'h41, 2'b10, 1'b0, '0, rd, lat, t0, again);
    n_tests++;
    if (rd !== 32'h12345678 || lat !== 6) begin
      n_fail++; $display("FAIL store_reload got=%h/lat%0d want=12345678/lat6", rd, lat);
    end
  endtask

  task automatic test_small_store;
    logic [31:0] rd; int lat, t0; logic again;
    run_mem(2'b10, 32'h50, 2'b00, 1'b0, 32'hDEADBEAB, rd, lat, t0, again);
    ref_store(32'h50, 1, 32'hDEADBEAB);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL byte_store_latency got=%0d want=2", lat); end
    run_mem(2'b10, 32'h52, 2'b01, 1'b0, 32'h55558001, rd, lat, t0, again);
    ref_store(32'h52, 2, 32'h55558001);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL half_store_latency got=%0d want=3", lat); end
    run_mem(2'b01, 32'h50, 2'b10, 1'b0, '0, rd, lat, t0, again);
    n_tests++;
    if (rd !== ref_load(32'h50, 4, 1'b0)) begin
      n_fail++; $display("FAIL small_store_reload got=%h want=%h", rd, ref_load(32'h50, 4, 1'b0));
    end
    run_mem(2'b01, 32'h52, 2'b01, 1'b0, '0, rd, lat, t0, again);
    n_tests++;
    if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL half_signed got=%h want=ffff8001", rd); end
  endtask

  task automatic test_arbitration;
    int md = -1, fd = -1;
    logic [31:0] mrd = '0, frd = '0;
    a_if_req = 1'b1; a_if_addr = 32'h100;
    a_mem_req = 2'b01; a_mem_addr = 32'h20; a_mem_size = 2'b10; a_mem_unsigned = 1'b0;
    for (int k = 1; k <= 40 && (md < 0 || fd < 0); k++) begin
      @(posedge clk); #1;
      if (a_mem_done && md < 0) begin md = k; mrd = a_mem_rdata; a_mem_req = 2'b00; end
      if (a_if_done && fd < 0) begin fd = k; frd = a_if_data; a_if_req = 1'b0; end
    end
    a_if_req = 1'b0; a_mem_req = 2'b00;
    @(posedge clk); #1;
    n_tests++;
    if (md !== 6 || fd !== 13) begin
      n_fail++; $display("FAIL arb_order mem_done@%0d if_done@%0d want 6 and 13", md, fd);
    end
    n_tests++;
    if (mrd !== ref_load(32'h20, 4, 1'b0) || frd !== 32'h00A00513) begin
      n_fail++; $display("FAIL arb_data got=%h/%h want=%h/00a00513", mrd, frd, ref_load(32'h20, 4, 1'b0));
    end
  endtask

  task automatic test_wrap;
    int lat = -1; logic [31:0] rd = '0; int bad = 0;
    poke_b(16'hFFFE, 8'h11); poke_b(16'hFFFF, 8'h22); poke_b(16'h0000, 8'h33); poke_b(16'h0001, 8'h44);
    b_mem_req = 2'b01; b_mem_addr = 16'hFFFE; b_mem_size = 2'b10; b_mem_unsigned = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k <= 4) begin
        n_tests++;
        if (b_ram_a !== 16'(32'hFFFE + 32'(k - 1)) || b_ram_wr !== 1'b0) begin
          n_fail++; bad++;
          $display("FAIL wrap_addr[%0d] got=%h wr=%b want=%h wr=0", k - 1, b_ram_a, b_ram_wr,
                   16'(32'hFFFE + 32'(k - 1)));
        end
      end
      if (b_mem_done) begin lat = k; rd = b_mem_rdata; end
    end
    b_mem_req = 2'b00;
    @(posedge clk); #1;
    n_tests++;
    if (lat !== 7 || rd !== 32'h44332211) begin
      n_fail++; $display("FAIL wrap_load got=%h/lat%0d want=44332211/lat7", rd, lat);
    end
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] rd; int lat, t0; logic again; int seen = 0;
    a_mem_req = 2'b10; a_mem_addr = 32'h300; a_mem_size = 2'b10; a_mem_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a_mem_req = 2'b00;
    n_tests++;
    if ({a_mem_done, a_if_done, a_busy, a_ram_wr} !== 4'b0000 ||
        {a_ram_a, a_ram_dout, a_mem_rdata, a_if_data} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs done=%b busy=%b wr=%b a=%h dout=%h rdata=%h idata=%h want all 0",
                         a_mem_done, a_busy, a_ram_wr, a_ram_a, a_ram_dout, a_mem_rdata, a_if_data);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (a_mem_done || a_busy) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d want=0", seen); end
    run_mem(2'b01, 32'h41, 2'b10, 1'b0, '0, rd, lat, t0, again);
    n_tests++;
    if (rd !== 32'h12345678 || lat !== 6) begin
      n_fail++; $display("FAIL midreset_recover got=%h/lat%0d want=12345678/lat6", rd, lat);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, addr, wd, exp_v, last_mem; int lat, t0, kind, n; logic [1:0] sz; logic uns, again;
    run_mem(2'b01, 32'h200, 2'b10, 1'b1, '0, rd, lat, t0, again);
    last_mem = ref_load(32'h200, 4, 1'b1);
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      addr = 32'h200 + 32'($urandom_range(0, 59));
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      if (kind == 0) begin
        run_fetch(addr, rd, lat, again);
        exp_v = ref_load(addr, 4, 1'b1);
        n_tests++;
        if (rd !== exp_v || lat !== 6 || again !== 1'b0) begin
          n_fail++; $display("FAIL rand_fetch[%0d] a=%h got=%h/lat%0d want=%h/lat6", it, addr, rd, lat, exp_v);
        end
      end else if (kind == 1) begin
        run_mem(2'b01, addr, sz, uns, '0, rd, lat, t0, again);
        exp_v = ref_load(addr, n, uns);
        last_mem = exp_v;
        n_tests++;
        if (rd !== exp_v || lat !== n + 2 || again !== 1'b0) begin
          n_fail++; $display("FAIL rand_load[%0d] a=%h sz=%0d u=%b got=%h/lat%0d want=%h/lat%0d",
                             it, addr, sz, uns, rd, lat, exp_v, n + 2);
        end
      end else begin
        run_mem(2'b10, addr, sz, uns, wd, rd, lat, t0, again);
        ref_store(addr, n, wd);
        n_tests++;
        if (lat !== n + 1 || a_mem_rdata !== last_mem) begin
          n_fail++; $display("FAIL rand_store[%0d] a=%h sz=%0d lat%0d rdata=%h want lat%0d rdata=%h",
                             it, addr, sz, lat, a_mem_rdata, n + 1, last_mem);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) refa[i] = 8'(i * 37 + 11);
    rst = 1'b1;
    a_if_req = 1'b0; a_if_addr = '0; a_mem_req = 2'b00; a_mem_addr = '0; a_mem_size = 2'b00;
    a_mem_unsigned = 1'b0; a_mem_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_mem_req = 2'b00; b_mem_addr = '0; b_mem_size = 2'b00;
    b_mem_unsigned = 1'b0; b_mem_wdata = '0;
    test_reset();
    test_fetch();
    test_load_ext();
    test_store_load();
    test_small_store();
    test_arbitration();
    test_wrap();
    test_reset_mid_store();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
